// File: rtl/pll_seq_ctrl.sv
// Reset/lock sequencer for the FOC-core rPLL: reset pulse, dynamic divider selects,
// debounced lock with timeout and bounded retry. Optional READY lock watchdog: PLL_LOCK_WATCHDOG_EN.
`timescale 1ns/1ps
module pll_seq_ctrl #(
   parameter logic [5:0] DEF_IDSEL     = 6'd7,
   parameter logic [5:0] DEF_FBDSEL    = 6'd10,
   parameter logic [5:0] DEF_ODSEL     = 6'd16,
   parameter int         RST_CYCLES    = 16,
   parameter int         LOCK_TIMEOUT  = 27000,
   parameter int         STABLE_CYCLES = 256,
   parameter int         MAX_RETRY     = 3
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       req,
   input  logic [5:0] req_idsel,
   input  logic [5:0] req_fbdsel,
   input  logic [5:0] req_odsel,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] pll_idsel,
   output logic [5:0] pll_fbdsel,
   output logic [5:0] pll_odsel,
   output logic       busy,
   output logic       clk_ready,
   output logic       fail,
   output logic [1:0] retry_cnt
);

   localparam int RW = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
   localparam int WW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

   localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
   localparam logic [WW-1:0] WIN_LAST    = WW'(LOCK_TIMEOUT - 1);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      RST_ASSERT,
      WAIT_LOCK,
      STABLE,
      READY,
      FAIL
   } state_t;

   state_t          state, state_next;
   logic            lock_meta, lock_s;
   logic [RW-1:0]   rst_cnt;
   logic [WW-1:0]   win_cnt;
   logic [SW-1:0]   stable_cnt;
   logic [1:0]      retry_next;

   logic rst_done, in_window, stable_done, expire, retry_last, req_acc;

   // pll_lock is asynchronous to clkin; only lock_s is used past this point
   always_ff @(posedge clkin) begin
      if (rst) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

   assign rst_done    = (state == RST_ASSERT) && (rst_cnt == RST_LAST);
   assign in_window   = (state == WAIT_LOCK) || (state == STABLE);
   assign stable_done = (state == STABLE) && lock_s && (stable_cnt == STABLE_LAST);
   // a stable run completing on the expiry edge still counts as a lock
   assign expire      = in_window && (win_cnt == WIN_LAST) && !stable_done;
   assign retry_next  = retry_cnt + 2'd1;
   assign retry_last  = (retry_next == RETRY_MAX);
   assign req_acc     = req && ((state == READY) || (state == FAIL));

   always_ff @(posedge clkin) begin
      if (rst) state <= RST_ASSERT;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RST_ASSERT: if (rst_done) state_next = WAIT_LOCK;
         WAIT_LOCK: begin
            if (expire)      state_next = retry_last ? FAIL : RST_ASSERT;
            else if (lock_s) state_next = STABLE;
         end
         STABLE: begin
            if (stable_done)  state_next = READY;
            else if (expire)  state_next = retry_last ? FAIL : RST_ASSERT;
            else if (!lock_s) state_next = WAIT_LOCK;
         end
         READY: begin
            if (req) state_next = RST_ASSERT;
`ifdef PLL_LOCK_WATCHDOG_EN
            else if (!lock_s) state_next = RST_ASSERT;
`endif
         end
         FAIL: if (req) state_next = RST_ASSERT;
         default: state_next = RST_ASSERT;
      endcase
   end

   always_comb begin
      pll_reset = 1'b0;
      busy      = 1'b0;
      clk_ready = 1'b0;
      fail      = 1'b0;
      case (state)
         RST_ASSERT: begin pll_reset = 1'b1; busy = 1'b1; end
         WAIT_LOCK:  busy = 1'b1;
         STABLE:     busy = 1'b1;
         READY:      clk_ready = 1'b1;
         FAIL:       begin pll_reset = 1'b1; fail = 1'b1; end
         default:    begin pll_reset = 1'b1; busy = 1'b1; end
      endcase
   end

   // counters restart on entry to their state; window spans WAIT_LOCK/STABLE bounces
   always_ff @(posedge clkin) begin
      if (rst) begin
         rst_cnt    <= '0;
         win_cnt    <= '0;
         stable_cnt <= '0;
      end else begin
         rst_cnt    <= (state == RST_ASSERT && state_next == RST_ASSERT) ? rst_cnt + RW'(1) : '0;
         win_cnt    <= (in_window && (state_next == WAIT_LOCK || state_next == STABLE))
                       ? win_cnt + WW'(1) : '0;
         stable_cnt <= (state == STABLE && state_next == STABLE) ? stable_cnt + SW'(1) : '0;
      end
   end

   // selects only move on a request accept, i.e. on entry to RST_ASSERT
   always_ff @(posedge clkin) begin
      if (rst) begin
         pll_idsel  <= DEF_IDSEL;
         pll_fbdsel <= DEF_FBDSEL;
         pll_odsel  <= DEF_ODSEL;
         retry_cnt  <= 2'd0;
      end else if (req_acc) begin
         pll_idsel  <= req_idsel;
         pll_fbdsel <= req_fbdsel;
         pll_odsel  <= req_odsel;
         retry_cnt  <= 2'd0;
      end else if (expire) begin
         retry_cnt  <= retry_next;
`ifdef PLL_LOCK_WATCHDOG_EN
      end else if (state == READY && !lock_s) begin
         retry_cnt  <= 2'd0;
`endif
      end
   end

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl: reconfiguration vector table with a select scoreboard,
// plus hand sequences for glitch, ignored req, lock drop, timeout/FAIL and mid-sequence rst.
`timescale 1ns/1ps
module tb_pll_seq_ctrl;

   logic       clkin = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic [5:0] req_idsel = '0, req_fbdsel = '0, req_odsel = '0;
   logic       pll_lock = 1'b0;
   logic       pll_reset, busy, clk_ready, fail;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic [1:0] retry_cnt;

   always #5 clkin = ~clkin;

   pll_seq_ctrl dut (
      .clkin(clkin), .rst(rst), .req(req),
      .req_idsel(req_idsel), .req_fbdsel(req_fbdsel), .req_odsel(req_odsel),
      .pll_lock(pll_lock), .pll_reset(pll_reset),
      .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
      .busy(busy), .clk_ready(clk_ready), .fail(fail), .retry_cnt(retry_cnt)
   );

   typedef struct {
      logic [5:0] i, f, o;
   } sel_t;

   typedef struct {
      logic [5:0] i, f, o;
      int         lock_delay;
      int         exp_rst_len;
      int         exp_ready;
   } vec_t;

   int   n_chk = 0;
   int   n_fail = 0;
   sel_t exp_q[$];
   sel_t cur;
   vec_t vecs[3];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clkin);
      #1;
   endtask

   // which: 0 = pll_reset low, 1 = pll_reset high, 2 = clk_ready high
   task automatic wait_for(input int which, input int limit, output int n);
      bit hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < limit) begin
         tick();
         n++;
         case (which)
            0:       hit = !pll_reset;
            1:       hit = pll_reset;
            default: hit = clk_ready;
         endcase
      end
   endtask

   task automatic chk_sel(input string tag);
      chk({tag, "_idsel"},  int'(pll_idsel),  int'(cur.i));
      chk({tag, "_fbdsel"}, int'(pll_fbdsel), int'(cur.f));
      chk({tag, "_odsel"},  int'(pll_odsel),  int'(cur.o));
   endtask

   task automatic sb_check();
      if (exp_q.size() == 0) begin
         chk("sb_queue_empty", 0, 1);
      end else begin
         cur = exp_q.pop_front();
         chk_sel("req_accept");
         chk("req_accept_pll_reset", int'(pll_reset), 1);
         chk("req_accept_busy",      int'(busy),      1);
         chk("req_accept_clk_ready", int'(clk_ready), 0);
         chk("req_accept_fail",      int'(fail),      0);
         chk("req_accept_retry",     int'(retry_cnt), 0);
      end
   endtask

   task automatic do_req(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o,
                         input bit accept);
      sel_t s;
      req = 1'b1;
      req_idsel = i;
      req_fbdsel = f;
      req_odsel = o;
      if (accept) begin
         s.i = i; s.f = f; s.o = o;
         exp_q.push_back(s);
      end
      tick();
      req = 1'b0;
      req_idsel = ~i;
      if (accept) sb_check();
   endtask

   // from the edge that started the reset pulse: pulse length, then lock and ready latency
   task automatic relock(input string tag, input int delay, input int exp_len, input int exp_rdy);
      int n;
      wait_for(0, exp_len + 50, n);
      chk({tag, "_rst_len"}, n, exp_len);
      chk_sel({tag, "_in_wait"});
      tick(delay);
      chk({tag, "_not_ready_yet"}, int'(clk_ready), 0);
      pll_lock = 1'b1;
      wait_for(2, exp_rdy + 50, n);
      chk({tag, "_lock_to_ready"}, n, exp_rdy);
      chk({tag, "_busy_ready"}, int'(busy), 0);
      chk({tag, "_retry_ready"}, int'(retry_cnt), 0);
      chk_sel({tag, "_ready"});
   endtask

   initial begin
      int n;
      vecs[0] = '{6'd5,  6'd20, 6'd8,  50,  16, 259};
      vecs[1] = '{6'd63, 6'd0,  6'd1,  7,   16, 259};
      vecs[2] = '{6'd0,  6'd63, 6'd42, 300, 16, 259};

      // reset state
      tick(3);
      cur.i = 6'd7; cur.f = 6'd10; cur.o = 6'd16;
      chk("rst_pll_reset", int'(pll_reset), 1);
      chk("rst_busy",      int'(busy),      1);
      chk("rst_clk_ready", int'(clk_ready), 0);
      chk("rst_fail",      int'(fail),      0);
      chk("rst_retry",     int'(retry_cnt), 0);
      chk_sel("rst");

      // power-up
      rst = 1'b0;
      relock("powerup", 100, 16, 259);

      // table-driven reconfiguration from READY
      foreach (vecs[k]) begin
         pll_lock = 1'b0;
         do_req(vecs[k].i, vecs[k].f, vecs[k].o, 1'b1);
         relock($sformatf("vec%0d", k), vecs[k].lock_delay, vecs[k].exp_rst_len, vecs[k].exp_ready);
      end

      // one-cycle lock glitch around stable count 200 restarts the debounce
      pll_lock = 1'b0;
      do_req(6'd33, 6'd12, 6'd4, 1'b1);
      wait_for(0, 100, n);
      chk("glitch_rst_len", n, 16);
      tick(20);
      pll_lock = 1'b1;
      tick(202);
      chk("glitch_pre_ready", int'(clk_ready), 0);
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      wait_for(2, 400, n);
      chk("glitch_relock_to_ready", n, 259);
      chk("glitch_retry", int'(retry_cnt), 0);

      // req during WAIT_LOCK is dropped
      pll_lock = 1'b0;
      do_req(6'd1, 6'd2, 6'd3, 1'b1);
      wait_for(0, 100, n);
      chk("waitreq_rst_len", n, 16);
      tick(5);
      do_req(6'd40, 6'd41, 6'd42, 1'b0);
      tick();
      chk_sel("waitreq_ignored");
      chk("waitreq_pll_reset", int'(pll_reset), 0);
      chk("waitreq_busy",      int'(busy),      1);
      tick(10);
      pll_lock = 1'b1;
      wait_for(2, 400, n);
      chk("waitreq_lock_to_ready", n, 259);
      chk_sel("waitreq_ready");

      // lock drop in READY
      pll_lock = 1'b0;
      tick(3);
`ifdef PLL_LOCK_WATCHDOG_EN
      chk("wd_clk_ready", int'(clk_ready), 0);
      chk("wd_pll_reset", int'(pll_reset), 1);
      chk("wd_retry",     int'(retry_cnt), 0);
      relock("wd", 40, 16, 259);
`else
      chk("nowd_clk_ready", int'(clk_ready), 1);
      chk("nowd_pll_reset", int'(pll_reset), 0);
      tick(20);
      chk("nowd_clk_ready_hold", int'(clk_ready), 1);
`endif

      // lock never asserts: three attempts then FAIL
      pll_lock = 1'b0;
      do_req(6'd9, 6'd9, 6'd9, 1'b1);
      for (int r = 1; r <= 3; r++) begin
         wait_for(0, 100, n);
         chk($sformatf("to%0d_rst_len", r), n, 16);
         wait_for(1, 27100, n);
         chk($sformatf("to%0d_window", r), n, 27000);
         chk($sformatf("to%0d_retry", r), int'(retry_cnt), r);
         chk($sformatf("to%0d_fail", r), int'(fail), (r == 3) ? 1 : 0);
         chk($sformatf("to%0d_busy", r), int'(busy), (r == 3) ? 0 : 1);
         chk_sel($sformatf("to%0d", r));
      end
      tick(50);
      chk("fail_hold_pll_reset", int'(pll_reset), 1);
      chk("fail_hold_fail",      int'(fail),      1);
      chk("fail_hold_clk_ready", int'(clk_ready), 0);
      do_req(6'd7, 6'd10, 6'd16, 1'b1);
      relock("after_fail", 30, 16, 259);

      // rst mid-sequence restarts with the default selects
      pll_lock = 1'b0;
      do_req(6'd20, 6'd21, 6'd22, 1'b1);
      tick(25);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cur.i = 6'd7; cur.f = 6'd10; cur.o = 6'd16;
      chk_sel("midrst");
      chk("midrst_pll_reset", int'(pll_reset), 1);
      chk("midrst_busy",      int'(busy),      1);
      chk("midrst_retry",     int'(retry_cnt), 0);
      relock("midrst", 60, 16, 259);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
